// File: rtl/multicycle_sequencer.sv
// One-hot phase sequencer for the simple-asm multi-cycle CPU: walks P1..P5,
// skipping unused phases, with memory wait/timeout, branches, HALT and retire count.
module multicycle_sequencer #(
  parameter int SKIP_PHASES = 1,
  parameter int WAIT_LIMIT  = 15,
  parameter int REG_AW      = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       ir,
  input  logic [3:0]        flags,
  input  logic              mem_ready,
  output logic [4:0]        phase,
  output logic              ir_we,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_addr_sel,
  output logic              op_ld,
  output logic              alu_b_imm,
  output logic [3:0]        alu_op,
  output logic              dr_we,
  output logic              mdr_we,
  output logic              out_we,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [1:0]        rf_wsel,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WCW-1:0] WL_V = WCW'(WAIT_LIMIT);

  typedef enum logic [6:0] {
    S_P1     = 7'b0000001,
    S_P2     = 7'b0000010,
    S_P3     = 7'b0000100,
    S_P4     = 7'b0001000,
    S_P5     = 7'b0010000,
    S_IDLE   = 7'b0100000,
    S_HALTED = 7'b1000000
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       flags_q, flags_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  logic is_load, is_store, is_lb, is_calc, is_cmp, is_out, is_halt;
  logic is_li, is_br, calc_wb, use_p4, use_p5, br_taken, timeout_hit;
  logic [WCW-1:0] wait_inc;
  logic unused_bits;

  assign is_load  = (ir[15:14] == 2'b00);
  assign is_store = (ir[15:14] == 2'b01);
  assign is_lb    = (ir[15:14] == 2'b10);
  assign is_calc  = (ir[15:14] == 2'b11);
  assign is_cmp   = is_calc && (ir[7:4] == 4'b0101);
  assign is_out   = is_calc && (ir[7:4] == 4'b1101);
  assign is_halt  = is_calc && (ir[7:4] == 4'b1111);
  assign is_li    = is_lb && (ir[13:11] == 3'b000);
  assign is_br    = is_lb && !is_li;
  assign calc_wb  = is_calc && !is_cmp && !is_out && !is_halt;
  assign use_p4   = is_load || is_store;
  assign use_p5   = is_load || is_li || calc_wb;

  // Flags are {V,C,Z,S}; carry is latched but no branch condition uses it.
  assign unused_bits = ^{ir[3:0], flags_q[2]};

  always_comb begin
    br_taken = 1'b0;
    if (ir[13:11] == 3'b100) begin
      br_taken = 1'b1;
    end else if (ir[13:11] == 3'b111) begin
      case (ir[10:8])
        3'b000:  br_taken = flags_q[1];
        3'b001:  br_taken = flags_q[0] ^ flags_q[3];
        3'b010:  br_taken = flags_q[1] | (flags_q[0] ^ flags_q[3]);
        3'b011:  br_taken = !flags_q[1];
        default: br_taken = 1'b0;
      endcase
    end
  end

  assign timeout_hit = (WAIT_LIMIT != 0) && (wait_q == WL_V) && !mem_ready;
  assign wait_inc    = (WAIT_LIMIT != 0) ? wait_q + WCW'(1) : '0;

  always_comb begin
    state_d      = state_q;
    flags_d      = flags_q;
    wait_d       = '0;
    cnt_d        = cnt_q;
    fault_d      = fault_q;
    ir_we        = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    op_ld        = 1'b0;
    alu_b_imm    = 1'b0;
    alu_op       = '0;
    dr_we        = 1'b0;
    mdr_we       = 1'b0;
    out_we       = 1'b0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wsel      = 2'b00;
    halted       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_P1;
      end
      S_HALTED: begin
        halted = 1'b1;
        if (start) begin
          state_d = S_P1;
          fault_d = 1'b0;
        end
      end
      S_P1: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_inc  = mem_ready;
        if (mem_ready) begin
          state_d = S_P2;
        end else if (timeout_hit) begin
          state_d = S_HALTED;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_P2: begin
        op_ld     = 1'b1;
        alu_b_imm = use_p4;
        state_d   = S_P3;
      end
      S_P3: begin
        if (is_calc) begin
          alu_op = ir[7:4];
          out_we = is_out;
          dr_we  = calc_wb || is_cmp;
          if (!is_out && !is_halt) flags_d = flags;
        end else if (use_p4) begin
          dr_we = 1'b1;
        end else if (is_br) begin
          pc_load = br_taken;
        end
        if (!use_p4 && !use_p5) cnt_d = cnt_q + CNT_W'(1);
        if (is_halt)                  state_d = S_HALTED;
        else if (SKIP_PHASES == 0)    state_d = S_P4;
        else if (use_p4)              state_d = S_P4;
        else if (use_p5)              state_d = S_P5;
        else                          state_d = S_P1;
      end
      S_P4: begin
        if (use_p4) begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_store;
          mdr_we       = is_load && mem_ready;
          if (mem_ready) begin
            state_d = ((SKIP_PHASES != 0) && !use_p5) ? S_P1 : S_P5;
            if (!use_p5) cnt_d = cnt_q + CNT_W'(1);
          end else if (timeout_hit) begin
            state_d = S_HALTED;
            fault_d = 1'b1;
          end else begin
            wait_d = wait_inc;
          end
        end else begin
          state_d = S_P5;
        end
      end
      S_P5: begin
        if (use_p5) begin
          rf_we = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (is_load) begin
            rf_waddr = REG_AW'(ir[13:11]);
            rf_wsel  = 2'b01;
          end else begin
            rf_waddr = REG_AW'(ir[10:8]);
            rf_wsel  = is_li ? 2'b10 : 2'b00;
          end
        end
        state_d = S_P1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      flags_q <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign phase       = state_q[4:0];
  assign fault       = fault_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Parametrised phase sequencer for the simple-asm multi-cycle CPU. It replaces the fixed free-running five-phase counter with a one-hot phase FSM that skips unused phases per instruction class, waits on a memory ready handshake, handles branches, HALT and bus faults, and counts retired instructions. It sits between the instruction register and the datapath: it reads the IR and ALU flags and drives every datapath enable strobe.

## Interface
- `SKIP_PHASES`, default 1: 1 skips phases an instruction does not use; 0 walks P1..P5 for every instruction with unused strobes suppressed (legacy timing).
- `WAIT_LIMIT`, default 15: maximum wait cycles on `mem_ready` per access; 0 means no limit.
- `REG_AW`, default 3: register-file address width.
- `CNT_W`, default 16: retired-instruction counter width.

- `clock` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: leave IDLE/HALTED and begin fetch.
- `ir` in 16: current instruction register contents.
- `flags` in 4: ALU flags {V,C,Z,S}, valid in P3.
- `mem_ready` in 1: memory access completes this cycle.
- `phase` out 5: one-hot P1..P5; 0 in IDLE and HALTED.
- `ir_we`, `pc_inc`, `pc_load` out 1: IR write, PC+1, PC load branch target.
- `mem_req`, `mem_we`, `mem_addr_sel` out 1: request, write, address select (0=PC, 1=DR).
- `op_ld` out 1: latch BR/AR.
- `alu_b_imm` out 1: BR sourced from ir[7:0].
- `alu_op` out 4: ALU function.
- `dr_we`, `mdr_we`, `out_we` out 1: DR, MDR and OUT result register writes.
- `rf_we` out 1: register-file write.
- `rf_waddr` out REG_AW: register-file write address.
- `rf_wsel` out 2: write source (00 DR, 01 MDR, 10 immediate).
- `halted`, `fault` out 1: stopped; stopped due to wait timeout.
- `instr_count` out CNT_W: retired instructions, wraps.

## Operation
- States: IDLE, P1 FETCH, P2 DECODE, P3 EXEC, P4 MEM, P5 WB, HALTED. The state register is one-hot. All strobes are Moore-decoded from state and `ir`; `mem_ready` gates strobes only where stated below.
- Class is ir[15:14]: 00 LOAD, 01 STORE, 10 LI/BRANCH, 11 CALC. The calc op is ir[7:4]: 0101 CMP, 1101 OUT, 1111 HALT.
- IDLE: `start`=1 moves to P1.
- P1: `mem_req`=1, `mem_addr_sel`=0.
  - `ir_we` and `pc_inc` = `mem_ready`.
  - On `mem_ready`, go to P2; otherwise stay and count a wait cycle.
- P2: `op_ld`=1. `alu_b_imm`=1 for LOAD/STORE. Go to P3.
- P3 by class:
  - CALC: `alu_op`=ir[7:4].
    - OUT: `out_we`.
    - HALT: go to HALTED.
    - Others: `dr_we`. Flags latch into `flags_q` for all calc ops except OUT/HALT.
  - LOAD/STORE: `alu_op`=0, `dr_we`.
  - BRANCH (ir[13:11]=100 unconditional; 111 conditional): condition ir[10:8] from `flags_q`.
    - 000 BE: Z.
    - 001 BLT: S^V.
    - 010 BLE: Z|(S^V).
    - 011 BNE: !Z.
    - Others: never taken.
    - `pc_load` = taken.
- P4 (LOAD/STORE): `mem_req`=1, `mem_addr_sel`=1.
  - STORE: `mem_we`=1.
  - LOAD: `mdr_we` = `mem_ready`.
  - Advance on `mem_ready`.
- P5: `rf_we`=1.
  - CALC: `rf_waddr`=ir[10:8], `rf_wsel`=00.
  - LOAD: `rf_waddr`=ir[13:11], `rf_wsel`=01.
  - LI (ir[13:11]=000): `rf_waddr`=ir[10:8], `rf_wsel`=10.
- Next phase after P3 when SKIP_PHASES=1:
  - LOAD/STORE → P4.
  - CALC (not CMP/OUT) and LI → P5.
  - CMP, OUT, BRANCH → P1.
  - STORE goes P4 → P1; LOAD goes P4 → P5.
- When SKIP_PHASES=0: P1→…→P5→P1. Skipped phases assert no strobes and ignore `mem_ready`.
- Retire: `instr_count`+1 on the cycle leaving the last used phase. HALT also retires.
- Timeout: the wait counter resets on each new access. When the count equals WAIT_LIMIT with `mem_ready`=0: go to HALTED, set `fault`, assert no strobes, no retire.
- HALTED: `halted`=1. `start` goes to P1 and clears `fault`. `instr_count` holds.

## Timing
- Reset (async, `reset_n`=0): state IDLE, `flags_q`=0, wait counter 0, `instr_count`=0, all outputs 0.
- Reset release is synchronous to the next `clock` edge. Reset mid-instruction abandons it with no strobes.
- Each phase is 1 cycle plus wait cycles in P1/P4. Consumers sample strobes on the rising edge that ends the phase.
- Zero-wait latency: CALC 4 cycles, LOAD 5, STORE 4, BRANCH/CMP/OUT 3, LI 4. With SKIP_PHASES=0, every instruction takes 5.
- `mem_ready` arriving in the same cycle the limit is reached counts as success.
- `start` is ignored outside IDLE/HALTED.

## Test plan
- Reset, then `start`, CALC ADD ir=0xC100, zero wait → phases P1,P2,P3,P5; `rf_we` in P5 with `rf_waddr`=1; `instr_count`=1 after 4 cycles.
- LOAD ir=0x0905 with `mem_ready` low 2 cycles in P4 → P4 lasts 3 cycles; `mdr_we` only in the last one; P5 `rf_waddr`=1, `rf_wsel`=01.
- CMP setting Z=1, then BE ir=0xB800 → `pc_load`=1 in P3, next state P1. Repeat with Z=0 → `pc_load`=0.
- HALT ir=0xC0F0 → `halted`=1 after P3; `instr_count` incremented; `start` restarts at P1.
- WAIT_LIMIT=3, `mem_ready` held 0 in P1 → HALTED with `fault`=1 after 3 wait cycles, no `ir_we`; `start` clears `fault`.
- SKIP_PHASES=0, BRANCH → 5 cycles, no strobes in P4/P5. Assert `reset_n` during P4 of a STORE → `mem_we` drops immediately, state IDLE.
